// File: rtl/kbd_event_queue.sv
// kbd_event_queue
//   Buffers Amiga raw keycodes in a small circular FIFO and presents them one
//   at a time to the downstream keyboard/mouse port, waiting for the CIA
//   handshake (KDAT pulled low) before moving on. A dropped write raises a
//   sticky overflow flag, and the 8'hFA "buffer overflow" code is sent ahead
//   of queued codes as soon as the FIFO has room.
//
//   Handshake: in_strobe is a one-tick request, accepted only on a clk7_en
//   tick; there is no ready, and a write into a full FIFO is dropped unless a
//   pop happens on the same tick. Downstream, each new code is announced by a
//   toggle of kms_level with kbd_mouse_data valid from that tick onward.
//
// Ports
//   clk, _reset       system clock, asynchronous active-low reset
//   clk7_en           7 MHz enable; all state advances only on this tick
//   in_strobe/in_data keycode write request
//   host_ack          handshake level from the host, sampled on clk7_en
//   kms_level         toggles once per code presented
//   kbd_mouse_data    code presented downstream
//   kbd_mouse_type    constant 2'd2 (keyboard)
//   busy              FSM not idle or FIFO non-empty
//   overflow          sticky dropped-write flag
//   level             FIFO occupancy
module kbd_event_queue #(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 1001000,
    parameter int GAP         = 1400,
    parameter int RETRIES     = 1
) (
    input  logic                       clk,
    input  logic                       _reset,
    input  logic                       clk7_en,
    input  logic                       in_strobe,
    input  logic [7:0]                 in_data,
    input  logic                       host_ack,
    output logic                       kms_level,
    output logic [7:0]                 kbd_mouse_data,
    output logic [1:0]                 kbd_mouse_type,
    output logic                       busy,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW          = $clog2(DEPTH);
    localparam int LW          = AW + 1;
    localparam int SHIFT_TICKS = 2048;
    localparam int MAX_AG      = (ACK_TIMEOUT > GAP) ? ACK_TIMEOUT : GAP;
    localparam int CNT_MAX     = (MAX_AG > SHIFT_TICKS) ? MAX_AG : SHIFT_TICKS;
    localparam int CW          = $clog2(CNT_MAX + 1);
    localparam int RW          = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);

    // The counter runs down from ACK_TIMEOUT-1 on the tick after SEND, so it
    // holds ACK_TIMEOUT-k at the k-th tick after SEND. The ack window opens
    // at k = 2048 (assumes ACK_TIMEOUT >= 2048).
    localparam logic [CW-1:0] ACK_LOAD = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] ACK_OPEN = CW'(ACK_TIMEOUT - SHIFT_TICKS);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [RW-1:0] RETRY_MAX = RW'(RETRIES);
    localparam logic [7:0]    OVF_CODE = 8'hFA;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   count_q, count_d;
    logic [7:0]      code_q, code_d;
    logic            is_fa_q, is_fa_d;
    logic [7:0]      data_q, data_d;
    logic            kms_q, kms_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   retry_q, retry_d;

    logic full, empty, fa_go, pop, wr_ok, drop, fa_done;

    assign full  = (count_q == FULL_LVL);
    assign empty = (count_q == '0);
    // A pending overflow code goes first, but only once a slot is free.
    assign fa_go = ovf_q && !full;
    assign pop   = clk7_en && (state_q == ST_IDLE) && !fa_go && !empty;
    // A pop on the same tick frees the slot the write needs.
    assign wr_ok = clk7_en && in_strobe && (!full || pop);
    assign drop  = clk7_en && in_strobe && full && !pop;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        is_fa_d  = is_fa_q;
        data_d   = data_q;
        kms_d    = kms_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        fa_done  = 1'b0;
        wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + LW'(wr_ok) - LW'(pop);

        if (clk7_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (fa_go) begin
                        code_d  = OVF_CODE;
                        is_fa_d = 1'b1;
                        state_d = ST_SEND;
                    end else if (!empty) begin
                        code_d  = mem_q[rd_ptr_q];
                        is_fa_d = 1'b0;
                        state_d = ST_SEND;
                    end
                end
                ST_SEND: begin
                    data_d  = code_q;
                    kms_d   = ~kms_q;
                    cnt_d   = ACK_LOAD;
                    state_d = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (host_ack && (cnt_q <= ACK_OPEN)) begin
                        fa_done = is_fa_q;
                        retry_d = '0;
                        cnt_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else if (cnt_q == '0) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + RW'(1);
                            state_d = ST_SEND;
                        end else begin
                            // Discarded; an unacked 8'hFA leaves overflow set
                            // so it is attempted again from IDLE.
                            retry_d = '0;
                            cnt_d   = GAP_LOAD;
                            state_d = ST_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A drop on the same tick as the 8'hFA ack keeps the flag set.
        ovf_d = (ovf_q && !fa_done) || drop;
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            code_q   <= '0;
            is_fa_q  <= 1'b0;
            data_q   <= '0;
            kms_q    <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            retry_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            code_q   <= code_d;
            is_fa_q  <= is_fa_d;
            data_q   <= data_d;
            kms_q    <= kms_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign kms_level      = kms_q;
    assign kbd_mouse_data = data_q;
    assign kbd_mouse_type = 2'd2;
    assign busy           = (state_q != ST_IDLE) || !empty;
    assign overflow       = ovf_q;
    assign level          = count_q;
endmodule

// File: tb/tb_kbd_event_queue.sv
module tb_kbd_event_queue;
    localparam int DEPTH       = 4;
    localparam int ACK_TIMEOUT = 3000;
    localparam int GAP_T       = 50;
    localparam int RETRIES     = 1;
    localparam int BUDGET      = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk7_en = 1'b0;
    logic       in_strobe = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       host_ack = 1'b0;
    logic       kms_level;
    logic [7:0] kbd_mouse_data;
    logic [1:0] kbd_mouse_type;
    logic       busy;
    logic       overflow;
    logic [2:0] level;

    kbd_event_queue #(
        .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT), .GAP(GAP_T), .RETRIES(RETRIES)
    ) dut (
        .clk(clk), ._reset(rst_n), .clk7_en(clk7_en), .in_strobe(in_strobe),
        .in_data(in_data), .host_ack(host_ack), .kms_level(kms_level),
        .kbd_mouse_data(kbd_mouse_data), .kbd_mouse_type(kbd_mouse_type),
        .busy(busy), .overflow(overflow), .level(level)
    );

    // ---------------- clock / enable ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(negedge clk) begin
        cyc++;
        clk7_en = ((cyc % 8) != 7);
    end

    int tick_cnt = 0;
    always @(posedge clk) if (clk7_en) tick_cnt++;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int         tog_t[$];
    int         checks = 0;
    int         failures = 0;
    int         last_s = 0;
    int         last_w = 0;
    int         idle_t = 0;
    logic       prev_kms = 1'b0;
    logic       prev_busy = 1'b0;

    // host model: 0 = never ack, 1 = ack ack_at ticks after a send unless the
    // code equals skip_code, 2 = ack held high
    int         ack_mode = 0;
    int         ack_at = 2048;
    logic [7:0] skip_code = 8'hFF;

    // ---------------- monitor + host ----------------
    always @(negedge clk) begin
        logic [7:0] e;
        int diff;
        if (!rst_n) begin
            prev_kms  = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (kms_level !== prev_kms) begin
                prev_kms = kms_level;
                tog_t.push_back(tick_cnt);
                last_s = tick_cnt;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got %h, no code expected", kbd_mouse_data);
                end else begin
                    e = exp_q.pop_front();
                    if (kbd_mouse_data !== e) begin
                        failures++;
                        $display("FAIL sb_code: got %h expected %h", kbd_mouse_data, e);
                    end
                end
            end
            if (prev_busy && !busy) idle_t = tick_cnt;
            prev_busy = busy;
        end
        diff = tick_cnt - last_s;
        case (ack_mode)
            1:       host_ack = (kbd_mouse_data != skip_code) && (diff >= ack_at - 1) && (diff < ack_at + 10);
            2:       host_ack = 1'b1;
            default: host_ack = 1'b0;
        endcase
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int tog_at(input int i);
        if (i < tog_t.size()) return tog_t[i];
        return -100000;
    endfunction

    // All driver tasks start and end at negedge+1.
    task automatic write_code(input logic [7:0] d);
        while (!clk7_en) begin @(negedge clk); #1; end
        in_strobe = 1'b1;
        in_data   = d;
        @(negedge clk); #1;
        last_w    = tick_cnt;
        in_strobe = 1'b0;
    endtask

    task automatic ghost_write(input logic [7:0] d);
        while (clk7_en) begin @(negedge clk); #1; end
        in_strobe = 1'b1;
        in_data   = d;
        @(negedge clk); #1;
        in_strobe = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int t0;
        t0 = tick_cnt;
        while (tick_cnt - t0 < n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_tick_eq(input int t);
        int b;
        b = 0;
        while (tick_cnt < t && b < BUDGET) begin @(negedge clk); #1; b++; end
    endtask

    task automatic wait_idle(input string name);
        int b;
        b = 0;
        while (busy && b < BUDGET) begin @(negedge clk); #1; b++; end
        chk(name, busy, 0);
    endtask

    task automatic wait_tog(input int n, input string name);
        int b;
        b = 0;
        while (tog_t.size() < n && b < BUDGET) begin @(negedge clk); #1; b++; end
        chk(name, tog_t.size(), n);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0;
        int n1;
        @(negedge clk); #1;

        // reset values
        chk("rst_kms", kms_level, 0);
        chk("rst_data", kbd_mouse_data, 8'h00);
        chk("rst_type", kbd_mouse_type, 2);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_level", level, 0);
        repeat (3) begin @(negedge clk); #1; end
        rst_n = 1'b1;
        wait_ticks(3);

        // single code, ack at tick 2100 after SEND
        ack_mode = 1; ack_at = 2100; skip_code = 8'hFF;
        n0 = tog_t.size();
        exp_q.push_back(8'h45);
        write_code(8'h45);
        wait_idle("idle_45");
        chk("send_latency", tog_at(n0) - last_w, 2);
        chk("ack2100_to_idle", idle_t - tog_at(n0), 2100 + GAP_T);
        chk("data_hold", kbd_mouse_data, 8'h45);

        // ack held high: accepted at the 2048th tick after SEND, not before
        ack_mode = 2;
        n0 = tog_t.size();
        exp_q.push_back(8'h33);
        write_code(8'h33);
        wait_idle("idle_33");
        ack_mode = 0;
        chk("ack_held_2048", idle_t - tog_at(n0), 2048 + GAP_T);

        // strobe without clk7_en is ignored
        n0 = tog_t.size();
        ghost_write(8'h77);
        wait_ticks(4);
        chk("ghost_level", level, 0);
        chk("ghost_busy", busy, 0);
        chk("ghost_no_send", tog_t.size(), n0);

        // timeout: 8'h20 sent twice then discarded; 8'h21 follows after GAP
        ack_mode = 1; ack_at = 2048; skip_code = 8'h20;
        n0 = tog_t.size();
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h21);
        write_code(8'h20);
        write_code(8'h21);
        wait_idle("idle_timeout");
        chk("resend_gap", tog_at(n0 + 1) - tog_at(n0), ACK_TIMEOUT + 1);
        chk("discard_gap", tog_at(n0 + 2) - tog_at(n0 + 1), ACK_TIMEOUT + GAP_T + 2);
        chk("timeout_sends", tog_t.size(), n0 + 3);

        // overflow: 01 is popped into flight at once, so 02..05 fill the
        // 4-deep FIFO and 06 is dropped. After 01 is acked the FIFO is still
        // full, so 02 goes next; 8'hFA follows as soon as a slot is free.
        skip_code = 8'hFF;
        n0 = tog_t.size();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'hFA);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h05);
        for (int i = 1; i <= 6; i++) write_code(8'(i));
        chk("ovf_level", level, 4);
        chk("ovf_set", overflow, 1);
        wait_idle("idle_ovf");
        chk("ovf_cleared", overflow, 0);
        chk("ovf_sends", tog_t.size(), n0 + 6);

        // write coincident with the pop from a full FIFO
        skip_code = 8'h53;
        n0 = tog_t.size();
        for (int i = 0; i < 6; i++) exp_q.push_back(8'h51 + 8'(i));
        for (int i = 0; i < 5; i++) write_code(8'h51 + 8'(i));
        chk("full_level", level, 4);
        wait_tick_eq(tog_at(n0) + 2048 + GAP_T);
        write_code(8'h56);
        chk("wr_pop_level", level, 4);
        chk("wr_pop_no_ovf", overflow, 0);
        wait_tog(n0 + 3, "wait_53");
        wait_ticks(1000);
        // 53 in flight, 54/55/56 queued: 56 was stored
        chk("queued_three", level, 3);
        chk("busy_wait_ack", busy, 1);

        // reset during WAIT_ACK with three codes queued
        ack_mode = 0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_kms", kms_level, 0);
        chk("mid_rst_data", kbd_mouse_data, 8'h00);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_level", level, 0);
        exp_q.delete();
        n1 = tog_t.size();
        repeat (5) begin @(negedge clk); #1; end
        rst_n = 1'b1;
        wait_ticks(2500);
        chk("post_rst_no_send", tog_t.size(), n1);
        chk("post_rst_busy", busy, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
